roi_crop_engine: RTL and testbench

ROI_CROP_ENGINE -- requirements
Module: roi_crop_engine

---
 rtl/roi_crop_engine.sv | 123 ++++++++++++
 tb/tb_roi_crop_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/roi_crop_engine.sv
// Streams a rectangular window of a source image out of a read port and writes it
// contiguously to a destination, one pixel per cycle with a two-stage read/write pipeline.
module roi_crop_engine #(
    parameter int IMG_W    = 200,
    parameter int IMG_H    = 150,
    parameter int DST_BASE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] xMin,
    input  logic [10:0] xMax,
    input  logic [10:0] yMin,
    input  logic [10:0] yMax,
    output logic [31:0] readAddr,
    input  logic [15:0] readdata,
    output logic [31:0] writeAddr,
    output logic [15:0] wrdata,
    output logic        wren,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

    localparam logic [31:0] IMG_W32 = IMG_W;
    localparam logic [31:0] IMG_H32 = IMG_H;
    localparam logic [31:0] DST32   = DST_BASE;

    state_t      state;
    logic [10:0] x, y, xMinL, xMaxL, yMaxL;
    logic [31:0] rowBase, wrCount;
    logic        reading, dataValid;
    logic        windowOk;

    assign windowOk = (xMin <= xMax) && ({21'b0, xMax} < IMG_W32) &&
                      (yMin <= yMax) && ({21'b0, yMax} < IMG_H32);

    // reading marks a cycle with a live address; dataValid marks the following cycle,
    // when the source memory returns that pixel and it is registered into a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            xMinL     <= '0;
            xMaxL     <= '0;
            yMaxL     <= '0;
            rowBase   <= '0;
            wrCount   <= '0;
            reading   <= 1'b0;
            dataValid <= 1'b0;
            readAddr  <= '0;
            writeAddr <= '0;
            wrdata    <= '0;
            wren      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wren      <= 1'b0;
            done      <= 1'b0;
            dataValid <= reading;
            if (dataValid) begin
                wren      <= 1'b1;
                wrdata    <= readdata;
                writeAddr <= DST32 + wrCount;
                wrCount   <= wrCount + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (windowOk) begin
                            state    <= STREAM;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            xMinL    <= xMin;
                            xMaxL    <= xMax;
                            yMaxL    <= yMax;
                            x        <= xMin;
                            y        <= yMin;
                            rowBase  <= {21'b0, yMin} * IMG_W32;
                            readAddr <= {21'b0, yMin} * IMG_W32 + {21'b0, xMin};
                            reading  <= 1'b1;
                            wrCount  <= '0;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // Row wrap keeps a running row base so no multiply is needed per pixel.
                    if (x == xMaxL && y == yMaxL) begin
                        state   <= DRAIN;
                        reading <= 1'b0;
                    end else if (x == xMaxL) begin
                        x        <= xMinL;
                        y        <= y + 11'd1;
                        rowBase  <= rowBase + IMG_W32;
                        readAddr <= rowBase + IMG_W32 + {21'b0, xMinL};
                    end else begin
                        x        <= x + 11'd1;
                        readAddr <= readAddr + 32'd1;
                    end
                end
                DRAIN: begin
                    if (!dataValid && !reading) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_roi_crop_engine.sv
// Testbench for roi_crop_engine: table of crop windows plus reset / re-start corner
// sequences, with a write scoreboard fed from an independent raster address model.
module tb_roi_crop_engine;

    localparam int IMG_W    = 200;
    localparam int IMG_H    = 150;
    localparam int DST_BASE = 0;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] xMin, xMax, yMin, yMax;
    logic [31:0] readAddr;
    logic [15:0] readdata;
    logic [31:0] writeAddr;
    logic [15:0] wrdata;
    logic        wren, busy, done, err;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        int xMin;
        int xMax;
        int yMin;
        int yMax;
        bit valid;
        int n;
        int firstAddr;
        int lastAddr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    vec_t vecs[7];
    wr_t  sb[$];

    roi_crop_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DST_BASE(DST_BASE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
        .readAddr(readAddr), .readdata(readdata),
        .writeAddr(writeAddr), .wrdata(wrdata), .wren(wren),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pix(input logic [31:0] a);
        return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Source memory with one cycle of read latency.
    always @(posedge clk) readdata <= pix(readAddr);

    task automatic checkOutput(input string name, input longint act, input longint exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int resetAt, input int repulseAt);
        int  expAddr[$];
        int  n;
        int  writes;
        int  dones;
        wr_t e;
        expAddr = {};
        for (int yy = v.yMin; yy <= v.yMax; yy++)
            for (int xx = v.xMin; xx <= v.xMax; xx++)
                expAddr.push_back(yy * IMG_W + xx);
        n = expAddr.size();
        sb.delete();
        writes = 0;
        dones  = 0;
        xMin = 11'(v.xMin); xMax = 11'(v.xMax);
        yMin = 11'(v.yMin); yMax = 11'(v.yMax);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= n + 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                xMin = 11'($urandom); xMax = 11'($urandom);
                yMin = 11'($urandom); yMax = 11'($urandom);
            end
            if (k == repulseAt + 1) start = 1'b0;
            if (k <= n) begin
                checkOutput("readAddr", readAddr, expAddr[k-1]);
                sb.push_back('{32'(DST_BASE + k - 1), pix(32'(expAddr[k-1]))});
            end else begin
                checkOutput("readAddrHold", readAddr, expAddr[n-1]);
            end
            if (k == 1) checkOutput("firstAddr", readAddr, v.firstAddr);
            if (k == n) checkOutput("lastAddr", readAddr, v.lastAddr);
            checkOutput("wren", wren, (k >= 3 && k <= n + 2));
            if (wren) begin
                writes++;
                if (sb.size() == 0) begin
                    assertions++;
                    failures++;
                    $display("[TB] FAIL sbUnderflow: got write at cycle %0d expected none", k);
                end else begin
                    e = sb.pop_front();
                    checkOutput("writeAddr", writeAddr, e.addr);
                    checkOutput("wrdata", wrdata, e.data);
                end
            end
            if (k > n + 2) checkOutput("writeAddrHold", writeAddr, DST_BASE + n - 1);
            checkOutput("busy", busy, (k <= n + 2));
            checkOutput("done", done, (k == n + 3));
            checkOutput("err", err, 0);
            if (done) dones++;
            if (k == repulseAt) start = 1'b1;
            if (k == resetAt) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("rstWren", wren, 0);
                checkOutput("rstBusy", busy, 0);
                checkOutput("rstDone", done, 0);
                checkOutput("rstErr", err, 0);
                checkOutput("rstReadAddr", readAddr, 0);
                checkOutput("rstWriteAddr", writeAddr, 0);
                sb.delete();
                return;
            end
        end
        checkOutput("writeCount", writes, n);
        checkOutput("doneCount", dones, 1);
        checkOutput("sbEmpty", sb.size(), 0);
    endtask

    task automatic applyInvalid(input vec_t v);
        xMin = 11'(v.xMin); xMax = 11'(v.xMax);
        yMin = 11'(v.yMin); yMax = 11'(v.yMax);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("invDone", done, 1);
        checkOutput("invErr", err, 1);
        checkOutput("invBusy", busy, 0);
        checkOutput("invWren", wren, 0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            checkOutput("invDoneLow", done, 0);
            checkOutput("invErrHeld", err, 1);
            checkOutput("invBusy", busy, 0);
            checkOutput("invWren", wren, 0);
        end
    endtask

    initial begin
        vecs[0] = '{10, 20, 60, 70, 1'b1, 121, 12010, 14020};
        vecs[1] = '{0, 0, 0, 0, 1'b1, 1, 0, 0};
        vecs[2] = '{198, 199, 0, 1, 1'b1, 4, 198, 399};
        vecs[3] = '{21, 20, 0, 5, 1'b0, 0, 0, 0};
        vecs[4] = '{0, 200, 0, 5, 1'b0, 0, 0, 0};
        vecs[5] = '{5, 7, 149, 149, 1'b1, 3, 29805, 29807};
        vecs[6] = '{0, 5, 10, 150, 1'b0, 0, 0, 0};

        rst = 1'b1;
        start = 1'b0;
        xMin = '0; xMax = '0; yMin = '0; yMax = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("resetReadAddr", readAddr, 0);
        checkOutput("resetWriteAddr", writeAddr, 0);
        checkOutput("resetWrdata", wrdata, 0);
        checkOutput("resetWren", wren, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetErr", err, 0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].valid) applyStimulus(vecs[i], -1, -1);
            else               applyInvalid(vecs[i]);
        end

        // Reset wins over a simultaneous start and also clears a held err.
        xMin = 11'd10; xMax = 11'd20; yMin = 11'd60; yMax = 11'd70;
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        checkOutput("rstStartBusy", busy, 0);
        checkOutput("rstStartErr", err, 0);
        checkOutput("rstStartDone", done, 0);
        @(negedge clk);
        checkOutput("rstStartIdle", busy, 0);
        checkOutput("rstStartNoWrite", wren, 0);

        applyStimulus(vecs[0], 50, -1);
        applyStimulus(vecs[0], -1, -1);
        applyStimulus(vecs[0], -1, 20);
        applyInvalid(vecs[3]);
        applyStimulus(vecs[1], -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
